// File: rtl/i2c_pkg.sv
// Shared I2C controller constants: FIFO geometry defaults and the status
// register bit positions the core uses when folding in FIFO flags.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;
  localparam int I2C_ADDR_WIDTH = 3;
  localparam int I2C_DEPTH      = 1 << I2C_ADDR_WIDTH;

  localparam int STATUS_TX_FULL_BIT  = 0;
  localparam int STATUS_TX_EMPTY_BIT = 1;
  localparam int STATUS_TX_OVF_BIT   = 2;
  localparam int STATUS_TX_UNF_BIT   = 3;

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; the owning FIFO masks stale data.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = I2C_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_tx_fifo.sv
// Transmit byte FIFO between the APB register block and the I2C byte engine.
// First-word-fall-through head, edge-detected writes, sticky error flags.
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = I2C_ADDR_WIDTH
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  wr_en_dly_q, wr_en_dly_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full;
  logic                  wr_req, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The extra MSB on each pointer distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // wr_en_i may stay high for a whole APB access; only its rise is a write.
  assign wr_req = wr_en_i & ~wr_en_dly_q;
  assign rd_ok  = rd_en_i & ~empty;
  assign wr_ok  = wr_req & (~full | rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_en_dly_d = wr_en_i;
    overflow_d  = overflow_q & ~clr_err_i;
    underflow_d = underflow_q & ~clr_err_i;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_req & full & ~rd_ok) begin
      overflow_d = 1'b1;
    end
    if (rd_en_i & empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_en_dly_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_en_dly_q <= wr_en_dly_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  i2c_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (pclk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  assign rd_data_o   = empty ? '0 : mem_rdata;
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Directed bench for i2c_tx_fifo: a byte queue holds expected FIFO contents,
// and flag models track the sticky overflow/underflow bits.
module tb_i2c_tx_fifo;

  logic       pclk = 1'b0;
  logic       preset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overflow, underflow;
  logic [3:0] count;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_unf;

  i2c_tx_fifo dut (
    .pclk_i      (pclk),
    .preset_i    (preset),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .clr_err_i   (clr_err),
    .rd_data_o   (rd_data),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(exp_q.size() == 8));
    chk({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(exp_unf));
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    cyc();
    if (exp_q.size() < 8) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop(input string tag);
    logic [7:0] e;
    chk({tag, "_notempty"}, 32'(empty), 32'd0);
    e = exp_q.pop_front();
    chk({tag, "_data"}, 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    preset  = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    cyc();
    cyc();
    chk_status("reset");
    chk("reset_rdata", 32'(rd_data), 32'h0);
    preset = 1'b0;
    cyc();

    // held write request stores exactly one byte
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    cyc();
    chk("hold_first_data", 32'(rd_data), 32'hA5);
    cyc();
    cyc();
    wr_en = 1'b0;
    cyc();
    exp_q.push_back(8'hA5);
    chk_status("hold");
    pop("hold_pop");
    chk_status("hold_drained");

    // fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk_status("fill");
    push(8'h09);
    chk_status("overflow");
    for (int i = 1; i <= 8; i++) pop("drain");
    chk_status("drained");
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    exp_ovf = 1'b0;
    chk_status("ovf_clear");

    // simultaneous write and pop while full
    for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
    chk("full_head", 32'(rd_data), 32'h21);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    rd_en   = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    cyc();
    chk_status("full_rw");
    for (int i = 0; i < 8; i++) pop("full_rw_drain");
    chk_status("full_rw_drained");

    // underflow, set wins over clear, clear alone
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    exp_unf = 1'b1;
    chk_status("unf");
    rd_en   = 1'b1;
    clr_err = 1'b1;
    cyc();
    rd_en   = 1'b0;
    clr_err = 1'b0;
    chk_status("unf_set_wins");
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    exp_unf = 1'b0;
    chk_status("unf_clear");

    // write plus pop on empty: write lands, pop rejected
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    rd_en   = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.push_back(8'h3C);
    exp_unf = 1'b1;
    chk_status("empty_rw");
    chk("empty_rw_data", 32'(rd_data), 32'h3C);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    exp_unf = 1'b0;
    pop("empty_rw_pop");
    chk_status("empty_rw_done");

    // pointer wrap with single write/pop pairs
    for (int i = 0; i < 20; i++) begin
      push(8'h10 + 8'(i));
      chk("wrap_count", 32'(count), 32'd1);
      pop("wrap");
    end
    chk_status("wrap_done");

    // async reset mid-stream with count 5 and overflow set
    for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) pop("pre_reset");
    chk_status("pre_reset");
    #2;
    preset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk_status("async_reset");
    chk("async_reset_rdata", 32'(rd_data), 32'h0);
    cyc();
    preset = 1'b0;
    cyc();
    push(8'hC3);
    chk_status("post_reset");
    pop("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
